// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined processor: instruction field
// positions, immediate widths, opcode constants and the datapath width default.
package cpu_pkg;

  localparam int DATA_W_DEF = 16;

  // Instruction field bit positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;
  localparam int RS_HI  = 10;
  localparam int RS_LO  = 8;
  localparam int RT_HI  = 7;
  localparam int RT_LO  = 5;
  localparam int RD_HI  = 4;
  localparam int RD_LO  = 2;

  // Immediate field widths (all start at bit 0)
  localparam int IMM5_W  = 5;
  localparam int IMM8_W  = 8;
  localparam int IMM11_W = 11;

  typedef enum logic [4:0] {
    OPC_ADD  = 5'd0,
    OPC_SUB  = 5'd1,
    OPC_AND  = 5'd2,
    OPC_OR   = 5'd3,
    OPC_ADDI = 5'd4,
    OPC_LW   = 5'd8,
    OPC_SW   = 5'd9,
    OPC_BEQ  = 5'd12,
    OPC_BNE  = 5'd13,
    OPC_J    = 5'd16,
    OPC_JAL  = 5'd17
  } opcode_e;

endpackage

// File: rtl/reg_file_bypass.sv
// Register file with two combinational read ports, one write port and
// write-before-read bypass. NUM_REGS is expected to be a power of two so that
// every index value addresses a real register.
module reg_file_bypass #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     rd_idx_a,
  input  logic [AW-1:0]     rd_idx_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage: cleared on reset, written at the edge when wr_en is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

  // Read ports: a same-cycle write to the addressed register wins
  always_comb begin
    rd_data_a = regs[rd_idx_a];
    rd_data_b = regs[rd_idx_b];
    if (wr_en && (wr_idx == rd_idx_a)) rd_data_a = wr_data;
    if (wr_en && (wr_idx == rd_idx_b)) rd_data_b = wr_data;
  end

endmodule

// File: rtl/pipe_decode_stage.sv
// Instruction-decode stage: register read with write-back bypass, immediate
// and branch/jump target generation, load-use hazard detection, and the
// registered ID/EX boundary.
//
// Pipeline control at each clk edge, highest priority first:
//   flush        -> ID/EX becomes a bubble (valid/reg_write/mem_read and all
//                   data fields cleared)
//   stall        -> ID/EX holds every field; operands are not re-read
//   hazard_stall -> ID/EX becomes a bubble while IF/ID holds its instruction
//   otherwise    -> ID/EX captures the decoded IF/ID contents
// hazard_stall is combinational, tells IF/ID to hold, and is masked by flush.
module pipe_decode_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc,
  input  logic              ctl_reg_write,
  input  logic              ctl_reg_dst,
  input  logic              ctl_mem_read,
  input  logic              ctl_uses_rt,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              hazard_stall,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_rs_data,
  output logic [DATA_W-1:0] id_rt_data,
  output logic [DATA_W-1:0] id_imm5,
  output logic [DATA_W-1:0] id_imm8,
  output logic [DATA_W-1:0] id_branch_addr,
  output logic [DATA_W-1:0] id_jump_addr,
  output logic [REG_AW-1:0] id_wr_reg,
  output logic              id_reg_write,
  output logic              id_mem_read,
  output logic [4:0]        id_opcode
);

  logic [REG_AW-1:0] rs_idx;
  logic [REG_AW-1:0] rt_idx;
  logic [REG_AW-1:0] dst_idx;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] imm5_ext;
  logic [DATA_W-1:0] imm8_ext;
  logic [DATA_W-1:0] imm11_ext;
  logic [DATA_W-1:0] branch_addr;
  logic [DATA_W-1:0] jump_addr;
  logic [4:0]        opcode;

  // Index fields are zero-extended or truncated to the register index width
  assign rs_idx  = REG_AW'(if_instr[RS_HI:RS_LO]);
  assign rt_idx  = REG_AW'(if_instr[RT_HI:RT_LO]);
  assign dst_idx = ctl_reg_dst ? REG_AW'(if_instr[RD_HI:RD_LO])
                               : REG_AW'(if_instr[RT_HI:RT_LO]);
  assign opcode  = if_instr[OPC_HI:OPC_LO];

  // Sign-extended immediates; target adds wrap modulo 2^DATA_W
  assign imm5_ext    = {{(DATA_W-IMM5_W){if_instr[IMM5_W-1]}},   if_instr[IMM5_W-1:0]};
  assign imm8_ext    = {{(DATA_W-IMM8_W){if_instr[IMM8_W-1]}},   if_instr[IMM8_W-1:0]};
  assign imm11_ext   = {{(DATA_W-IMM11_W){if_instr[IMM11_W-1]}}, if_instr[IMM11_W-1:0]};
  assign branch_addr = if_pc + imm8_ext;
  assign jump_addr   = if_pc + imm11_ext;

  reg_file_bypass #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .rd_idx_a  (rs_idx),
    .rd_idx_b  (rt_idx),
    .rd_data_a (rs_data),
    .rd_data_b (rt_data),
    .wr_en     (wb_en),
    .wr_idx    (wb_reg),
    .wr_data   (wb_data)
  );

  // Load-use: a valid load in ID/EX targets a register this instruction reads
  assign hazard_stall = ~flush & if_valid & id_valid & id_mem_read & id_reg_write &
                        ((id_wr_reg == rs_idx) | (ctl_uses_rt & (id_wr_reg == rt_idx)));

  // ID/EX boundary: flush, then stall, then hazard bubble, then capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush || (!stall && hazard_stall)) begin
      id_valid       <= 1'b0;
      id_rs_data     <= '0;
      id_rt_data     <= '0;
      id_imm5        <= '0;
      id_imm8        <= '0;
      id_branch_addr <= '0;
      id_jump_addr   <= '0;
      id_wr_reg      <= '0;
      id_reg_write   <= 1'b0;
      id_mem_read    <= 1'b0;
      id_opcode      <= '0;
    end else if (!stall) begin
      id_valid       <= if_valid;
      id_rs_data     <= rs_data;
      id_rt_data     <= rt_data;
      id_imm5        <= imm5_ext;
      id_imm8        <= imm8_ext;
      id_branch_addr <= branch_addr;
      id_jump_addr   <= jump_addr;
      id_wr_reg      <= dst_idx;
      id_reg_write   <= ctl_reg_write & if_valid;
      id_mem_read    <= ctl_mem_read & if_valid;
      id_opcode      <= opcode;
    end
  end

endmodule

// File: tb/tb_pipe_decode_stage.sv
// Self-checking bench for pipe_decode_stage: reset state, a table of decode
// vectors with hand-computed results, and hand-written hazard, stall, flush
// and asynchronous-reset sequences.
module tb_pipe_decode_stage;

  typedef struct packed {
    logic        valid;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] imm5;
    logic [15:0] imm8;
    logic [15:0] br;
    logic [15:0] jmp;
    logic [2:0]  wr_reg;
    logic        rw;
    logic        mr;
    logic [4:0]  opc;
  } out_t;

  typedef struct packed {
    logic        v;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        rw;
    logic        dst;
    logic        mr;
    logic        urt;
    logic        we;
    logic [2:0]  wr;
    logic [15:0] wd;
    out_t        exp;
  } vec_t;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        ctl_reg_write, ctl_reg_dst, ctl_mem_read, ctl_uses_rt;
  logic        stall, flush;
  logic        wb_en;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        hazard_stall, id_valid;
  logic [15:0] id_rs_data, id_rt_data, id_imm5, id_imm8, id_branch_addr, id_jump_addr;
  logic [2:0]  id_wr_reg;
  logic        id_reg_write, id_mem_read;
  logic [4:0]  id_opcode;

  pipe_decode_stage #(.DATA_W(16), .NUM_REGS(8), .REG_AW(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .ctl_reg_write  (ctl_reg_write),
    .ctl_reg_dst    (ctl_reg_dst),
    .ctl_mem_read   (ctl_mem_read),
    .ctl_uses_rt    (ctl_uses_rt),
    .stall          (stall),
    .flush          (flush),
    .wb_en          (wb_en),
    .wb_reg         (wb_reg),
    .wb_data        (wb_data),
    .hazard_stall   (hazard_stall),
    .id_valid       (id_valid),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .id_imm5        (id_imm5),
    .id_imm8        (id_imm8),
    .id_branch_addr (id_branch_addr),
    .id_jump_addr   (id_jump_addr),
    .id_wr_reg      (id_wr_reg),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .id_opcode      (id_opcode)
  );

  // Scoreboard state
  out_t        exp_q[$];
  out_t        last_exp;
  logic [15:0] rf_m [8];
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl [6];

  function automatic out_t get_act();
    out_t a;
    a.valid   = id_valid;
    a.rs_data = id_rs_data;
    a.rt_data = id_rt_data;
    a.imm5    = id_imm5;
    a.imm8    = id_imm8;
    a.br      = id_branch_addr;
    a.jmp     = id_jump_addr;
    a.wr_reg  = id_wr_reg;
    a.rw      = id_reg_write;
    a.mr      = id_mem_read;
    a.opc     = id_opcode;
    return a;
  endfunction

  // Reference decode of the currently driven IF/ID inputs
  function automatic out_t model();
    out_t o;
    logic [2:0] rs;
    logic [2:0] rt;
    rs        = if_instr[10:8];
    rt        = if_instr[7:5];
    o.valid   = if_valid;
    o.rs_data = (wb_en && wb_reg == rs) ? wb_data : rf_m[rs];
    o.rt_data = (wb_en && wb_reg == rt) ? wb_data : rf_m[rt];
    o.imm5    = {{11{if_instr[4]}}, if_instr[4:0]};
    o.imm8    = {{8{if_instr[7]}}, if_instr[7:0]};
    o.br      = if_pc + o.imm8;
    o.jmp     = if_pc + {{5{if_instr[10]}}, if_instr[10:0]};
    o.wr_reg  = ctl_reg_dst ? if_instr[4:2] : if_instr[7:5];
    o.rw      = ctl_reg_write & if_valid;
    o.mr      = ctl_mem_read & if_valid;
    o.opc     = if_instr[15:11];
    return o;
  endfunction

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: hazard_stall got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: id/ex got %h expected %h", name, got, exp);
    end
  endtask

  // Driver
  task automatic apply(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic rw, input logic dst, input logic mr, input logic urt,
                       input logic st, input logic fl,
                       input logic we, input logic [2:0] wr, input logic [15:0] wd);
    if_valid      = v;
    if_instr      = ins;
    if_pc         = pc;
    ctl_reg_write = rw;
    ctl_reg_dst   = dst;
    ctl_mem_read  = mr;
    ctl_uses_rt   = urt;
    stall         = st;
    flush         = fl;
    wb_en         = we;
    wb_reg        = wr;
    wb_data       = wd;
  endtask

  // One clock: check hazard, push expected, clock, pop and compare
  task automatic check_cycle(input out_t e, input logic exp_hz, input string name);
    out_t got;
    out_t want;
    #1;
    chk1({name, "_hz"}, hazard_stall, exp_hz);
    exp_q.push_back(e);
    @(posedge clk);
    if (wb_en) rf_m[wb_reg] = wb_data;
    #1;
    got  = get_act();
    want = exp_q.pop_front();
    chk_out(name, got, want);
    last_exp = e;
  endtask

  task automatic step(input logic exp_hz, input string name);
    out_t e;
    if (flush)       e = '0;
    else if (stall)  e = last_exp;
    else if (exp_hz) e = '0;
    else             e = model();
    check_cycle(e, exp_hz, name);
  endtask

  task automatic read_all(input string name);
    logic [15:0] ins;
    for (int i = 0; i < 8; i++) begin
      ins = {5'd0, 3'(i), 3'(7 - i), 5'd0};
      apply(1'b1, ins, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      step(1'b0, $sformatf("%s_r%0d", name, i));
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] r_ins;
    // Table: hand-computed decode results (no stall/flush, no hazards)
    tbl[0] = '{1'b1, 16'h0B00, 16'h0020, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 16'hBEEF,
               '{1'b1, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 16'h0320, 3'd0, 1'b1, 1'b0, 5'd1}};
    tbl[1] = '{1'b1, 16'h107F, 16'h0100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 16'h1234,
               '{1'b1, 16'h0000, 16'hBEEF, 16'hFFFF, 16'h007F, 16'h017F, 16'h017F, 3'd7, 1'b1, 1'b0, 5'd2}};
    tbl[2] = '{1'b1, 16'h1DFC, 16'h0010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000,
               '{1'b1, 16'h1234, 16'h0000, 16'hFFFC, 16'hFFFC, 16'h000C, 16'hFE0C, 3'd7, 1'b0, 1'b1, 5'd3}};
    tbl[3] = '{1'b1, 16'h2400, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000,
               '{1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 16'hFC10, 3'd0, 1'b1, 1'b0, 5'd4}};
    tbl[4] = '{1'b1, 16'h2E04, 16'hFFFE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 16'hA5A5,
               '{1'b1, 16'hA5A5, 16'h0000, 16'h0004, 16'h0004, 16'h0002, 16'hFE02, 3'd1, 1'b1, 1'b0, 5'd5}};
    tbl[5] = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000,
               '{1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd7, 1'b0, 1'b0, 5'd31}};

    for (int i = 0; i < 8; i++) rf_m[i] = '0;
    last_exp = '0;

    // Reset state
    rst = 1'b1;
    apply(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    #12;
    chk_out("reset_state", get_act(), '0);
    chk1("reset_hz", hazard_stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // All registers read as zero; first capture after reset is normal
    read_all("rd_reset");

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      apply(tbl[i].v, tbl[i].instr, tbl[i].pc, tbl[i].rw, tbl[i].dst, tbl[i].mr, tbl[i].urt,
            1'b0, 1'b0, tbl[i].we, tbl[i].wr, tbl[i].wd);
      check_cycle(tbl[i].exp, 1'b0, $sformatf("table%0d", i));
    end

    // Load-use hazard on rs, masked by flush, then bubble
    apply(1'b1, 16'h4040, 16'h0200, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    step(1'b0, "load_r2");
    apply(1'b1, 16'h4A00, 16'h0202, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
    #1;
    chk1("flush_masks_hazard", hazard_stall, 1'b0);
    flush = 1'b0;
    step(1'b1, "hazard_rs_bubble");
    // Load again, then rs=5 does not collide
    apply(1'b1, 16'h4040, 16'h0204, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    step(1'b0, "load_r2_b");
    apply(1'b1, 16'h4D00, 16'h0300, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    step(1'b0, "no_hazard_rs5");
    // Load again, rt=2 collides only when Rt is used
    apply(1'b1, 16'h4040, 16'h0206, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    step(1'b0, "load_r2_c");
    apply(1'b1, 16'h5040, 16'h0400, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    #1;
    chk1("hazard_rt_used", hazard_stall, 1'b1);
    ctl_uses_rt = 1'b0;
    step(1'b0, "no_hazard_rt_unused");

    // Stall holds ID/EX for 3 cycles while inputs and write-back change
    r_ins = 16'($urandom_range(0, 16'hFFFF));
    apply(1'b1, r_ins, 16'($urandom_range(0, 16'hFFFF)), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1,
          1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    step(1'b0, "pre_stall");
    for (int i = 0; i < 3; i++) begin
      r_ins = 16'($urandom_range(0, 16'hFFFF));
      apply(1'b1, r_ins, 16'($urandom_range(0, 16'hFFFF)), 1'b1, 1'b0, 1'b0, 1'b1,
            1'b1, 1'b0, 1'b1, 3'($urandom_range(0, 7)), 16'($urandom_range(1, 16'hFFFF)));
      step(1'b0, $sformatf("stall_hold%0d", i));
    end
    apply(1'b1, 16'h1234, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0);
    step(1'b0, "flush_over_stall");

    // Randomised captures with write-back traffic
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)), 1'b1,
            1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 1'b0,
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom_range(1, 16'hFFFF)));
      step(1'b0, $sformatf("rand%0d", i));
    end

    // Asynchronous reset between edges clears ID/EX immediately
    apply(1'b1, 16'h3B7F, 16'h0800, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    step(1'b0, "pre_reset");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_out("async_reset", get_act(), '0);
    for (int i = 0; i < 8; i++) rf_m[i] = '0;
    last_exp = '0;
    @(negedge clk);
    rst = 1'b0;
    read_all("rd_after_rst");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_decode_stage.md
Name: pipe_decode_stage

Overview:
- Parametrised instruction-decode stage for the pipelined 16-bit processor.
- Sits between the IF/ID register and the execute stage.
- Contains the register file with write-back bypass, immediate and target generation, and load-use hazard detection.
- Ends in a registered ID/EX pipeline boundary with stall, bubble and flush control.

Parameters:
- DATA_W, 16, datapath and register width.
- NUM_REGS, 8, number of architectural registers.
- REG_AW, 3, register index width; must equal clog2(NUM_REGS).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- if_valid  in  1  IF/ID holds a real instruction
- if_instr  in  16  instruction word
- if_pc  in  DATA_W  PC+2 of the instruction
- ctl_reg_write  in  1  instruction writes a register (from control unit)
- ctl_reg_dst  in  1  1: dest = instr[4:2]; 0: dest = instr[7:5]
- ctl_mem_read  in  1  instruction is a load
- ctl_uses_rt  in  1  instruction reads Rt
- stall  in  1  downstream stall; hold ID/EX
- flush  in  1  branch mispredict; squash ID/EX
- wb_en  in  1  write-back enable
- wb_reg  in  REG_AW  write-back register index
- wb_data  in  DATA_W  write-back data
- hazard_stall  out  1  load-use hazard; IF/ID must hold
- id_valid  out  1  ID/EX contents valid
- id_rs_data  out  DATA_W  Rs operand
- id_rt_data  out  DATA_W  Rt operand
- id_imm5  out  DATA_W  sext(instr[4:0])
- id_imm8  out  DATA_W  sext(instr[7:0])
- id_branch_addr  out  DATA_W  if_pc + sext(instr[7:0])
- id_jump_addr  out  DATA_W  if_pc + sext(instr[10:0])
- id_wr_reg  out  REG_AW  destination register
- id_reg_write  out  1  qualified register-write enable
- id_mem_read  out  1  qualified load flag
- id_opcode  out  5  instr[15:11]

Behaviour:
- Clocking and reset: one clock domain (clk). rst is asynchronous and active-high.
- Reset values: all ID/EX outputs and all register-file entries are 0.
- Field map:
  - rs = instr[10:8], rt = instr[7:5].
  - Dest: instr[4:2] if ctl_reg_dst=1, else instr[7:5].
  - Index fields are truncated/zero-extended to REG_AW.
- Register file:
  - NUM_REGS x DATA_W flops.
  - Written at the clock edge when wb_en=1.
  - Reads are combinational.
  - Bypass: if wb_en and wb_reg equals the read index, the read returns wb_data in the same cycle (write-before-read).
  - No hardwired-zero register.
- Arithmetic:
  - Sign extension replicates the MSB to DATA_W.
  - Address adds are modulo 2^DATA_W; carry out is dropped.
- hazard_stall is combinational:
  - Asserts when if_valid & id_valid & id_mem_read & id_reg_write, and id_wr_reg==rs or (ctl_uses_rt & id_wr_reg==rt).
  - Forced to 0 while flush=1.
- ID/EX update at each edge, in priority order:
  1. flush: id_valid, id_reg_write and id_mem_read go to 0; data fields are don't-care (cleared to 0).
  2. stall: all ID/EX fields hold their value.
  3. hazard_stall: bubble is inserted (same as flush).
  4. Otherwise: capture. id_valid=if_valid. id_reg_write=ctl_reg_write&if_valid. id_mem_read=ctl_mem_read&if_valid.
- Latency: 1 cycle from IF/ID inputs to ID/EX outputs.
- Held ID/EX operands are not re-read from the register file. Hazards against held data are the forwarding unit's responsibility.
- Simultaneous wb_en and a read of the same register: bypassed value is captured.
- Reset asserted mid-stall: contents are cleared immediately and the stall state is lost.
- First cycle after reset release: captures normally.

Decomposition:
- Shared package (cpu_pkg) holds:
  - Instruction field bit positions (OPC_HI/LO, RS/RT/RD ranges).
  - Immediate widths (5, 8, 11).
  - Opcode constants.
  - DATA_W default.
- One sub-module: reg_file_bypass.
  - Parameters DATA_W and NUM_REGS.
  - Two read ports, one write port, internal bypass, async reset.

Test Plan:
1. Reset, then read all registers with if_valid=1 -> id_rs_data=id_rt_data=0 for every index; id_valid=1 one cycle later.
2. wb_en=1, wb_reg=3, wb_data=16'hBEEF in the same cycle as if_instr rs=3 -> id_rs_data=16'hBEEF after one edge; a later read of R3 also returns BEEF.
3. if_pc=16'h0010 with instr[7:0]=8'hFC and instr[10:0]=11'h400 -> id_branch_addr=16'h000C, id_jump_addr=16'hFC10; if_pc=16'hFFFE with imm8=8'h04 -> id_branch_addr=16'h0002 (wrap).
4. Load writing R2 in ID/EX, next instr rs=2 -> hazard_stall=1, ID/EX gets bubble (id_valid=0, id_reg_write=0); retry with rs=5 -> no hazard; ctl_uses_rt=0 with rt=2 -> no hazard.
5. stall=1 for 3 cycles while inputs change -> ID/EX outputs unchanged; flush and stall both 1 -> id_valid=0.
6. Assert rst mid-operation (asynchronously, between edges) -> all outputs 0 before the next clk edge; register file reads 0 afterwards.
